// File: rtl/seq_det_prog.sv
// Programmable serial sequence detector: compares the last N accepted bits against a
// runtime-loadable pattern, pulses det on a match and keeps a saturating match count.
module seq_det_prog #(
    parameter int           N       = 3,
    parameter logic [N-1:0] PATTERN = 3'b001,
    parameter bit           OVERLAP = 1'b1,
    parameter int           CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inp,
    input  logic             in_valid,
    input  logic             pat_load,
    input  logic [N-1:0]     pat_in,
    input  logic             cnt_clr,
    output logic             det,
    output logic [CNT_W-1:0] det_cnt,
    output logic [N-1:0]     pat_cur
);

    localparam int             FW   = $clog2(N + 1);
    localparam logic [FW-1:0]  FULL = FW'(N);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [N-1:0]     hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [N-1:0]     pat_q, pat_d;
    logic             det_q, det_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N-1:0]  hist_shift;
    logic [FW-1:0] fill_inc;
    logic          match;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a
        // signal unassigned, which would otherwise infer a latch.
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        det_d  = 1'b0;
        cnt_d  = cnt_q;

        hist_shift = {hist_q[N-2:0], inp};
        fill_inc   = (fill_q == FULL) ? FULL : fill_q + FW'(1);
        // The fill gate keeps reset zeros in hist from ever counting as received bits.
        match      = !pat_load && in_valid && (fill_inc == FULL) && (hist_shift == pat_q);

        if (pat_load) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            det_d = match;
            if (match && !OVERLAP) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = hist_shift;
                fill_d = fill_inc;
            end
        end

        // Clear wins over a same-edge match; the match still pulses det.
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (match && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // the pre-edge values, independent of statement order.
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= PATTERN;
            det_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            det_q  <= det_d;
            cnt_q  <= cnt_d;
        end
    end

    assign det     = det_q;
    assign det_cnt = cnt_q;
    assign pat_cur = pat_q;

endmodule

// File: tb/tb_seq_det_prog.sv
// Bench for seq_det_prog: three instances (overlap, non-overlap, 2-bit counter) share one
// directed stimulus and are checked every cycle against a bit-count/window model.
module tb_seq_det_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inp = 1'b0;
    logic       in_valid = 1'b0;
    logic       pat_load = 1'b0;
    logic [2:0] pat_in = 3'b000;
    logic       cnt_clr = 1'b0;

    logic       det0, det1, det2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;
    logic [2:0] pat0, pat1, pat2;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state per instance: bits accepted since last discard, last-3-bit window value.
    int m_len [3];
    int m_val [3];
    int m_pat [3];
    int m_det [3];
    int m_cnt [3];
    int ovl   [3] = '{1, 0, 1};
    int cmax  [3] = '{255, 255, 3};

    always #5 clk = ~clk;

    seq_det_prog u_ovl (
        .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .pat_load(pat_load),
        .pat_in(pat_in), .cnt_clr(cnt_clr), .det(det0), .det_cnt(cnt0), .pat_cur(pat0)
    );

    seq_det_prog #(.OVERLAP(1'b0)) u_novl (
        .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .pat_load(pat_load),
        .pat_in(pat_in), .cnt_clr(cnt_clr), .det(det1), .det_cnt(cnt1), .pat_cur(pat1)
    );

    seq_det_prog #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .pat_load(pat_load),
        .pat_in(pat_in), .cnt_clr(cnt_clr), .det(det2), .det_cnt(cnt2), .pat_cur(pat2)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, v, b, l, input logic [2:0] p, input logic c);
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                m_len[i] = 0; m_val[i] = 0; m_pat[i] = 1; m_det[i] = 0; m_cnt[i] = 0;
            end else begin
                m_det[i] = 0;
                if (l) begin
                    m_pat[i] = int'(p); m_len[i] = 0; m_val[i] = 0;
                end else if (v) begin
                    m_val[i] = (m_val[i] * 2 + int'(b)) % 8;
                    m_len[i] = m_len[i] + 1;
                    if (m_len[i] >= 3 && m_val[i] == m_pat[i]) begin
                        m_det[i] = 1;
                        if (m_cnt[i] < cmax[i]) m_cnt[i] = m_cnt[i] + 1;
                        if (ovl[i] == 0) begin
                            m_len[i] = 0; m_val[i] = 0;
                        end
                    end
                end
                if (c) m_cnt[i] = 0;
            end
        end
    endtask

    task automatic step(input logic r, v, b, l, input logic [2:0] p, input logic c);
        rst = r; in_valid = v; inp = b; pat_load = l; pat_in = p; cnt_clr = c;
        @(posedge clk);
        model_update(r, v, b, l, p, c);
        @(negedge clk);
    endtask

    task automatic bit_in(input logic b);
        step(1'b0, 1'b1, b, 1'b0, 3'b000, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    endtask

    task automatic load(input logic [2:0] p);
        step(1'b0, 1'b0, 1'b0, 1'b1, p, 1'b0);
    endtask

    // Single compare process: every instance, every cycle once reset has been applied.
    always @(negedge clk) begin
        if (chk_en) begin
            check("det[0]", int'(det0), m_det[0]);
            check("det[1]", int'(det1), m_det[1]);
            check("det[2]", int'(det2), m_det[2]);
            check("cnt[0]", int'(cnt0), m_cnt[0]);
            check("cnt[1]", int'(cnt1), m_cnt[1]);
            check("cnt[2]", int'(cnt2), m_cnt[2]);
            check("pat[0]", int'(pat0), m_pat[0]);
            check("pat[1]", int'(pat1), m_pat[1]);
            check("pat[2]", int'(pat2), m_pat[2]);
        end
    end

    initial begin
        logic s1_bits [10] = '{0, 0, 1, 1, 0, 0, 1, 1, 1, 0};
        int   s1_det  [10] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
        logic s2_bits [5]  = '{1, 0, 1, 0, 1};
        int   s2_det  [5]  = '{0, 0, 1, 0, 1};
        int   s4_cnt  [6]  = '{0, 0, 1, 2, 3, 3};

        do_reset();
        chk_en = 1'b1;
        check("reset_det", int'(det0), 0);
        check("reset_cnt", int'(cnt0), 0);
        check("reset_pat", int'(pat0), 1);

        // Default pattern 001 on a mixed stream.
        for (int i = 0; i < 10; i++) begin
            bit_in(s1_bits[i]);
            check($sformatf("s1_det_bit%0d", i + 1), int'(det0), s1_det[i]);
        end
        check("s1_cnt", int'(cnt0), 2);
        check("s1_cnt_novl", int'(cnt1), 2);

        // Pattern 101: overlap vs non-overlap.
        do_reset();
        load(3'b101);
        for (int i = 0; i < 5; i++) begin
            bit_in(s2_bits[i]);
            check($sformatf("s2_det_bit%0d", i + 1), int'(det0), s2_det[i]);
        end
        check("s2_cnt_ovl", int'(cnt0), 2);
        check("s2_cnt_novl", int'(cnt1), 1);

        // Fill gate: pattern 000, two zeros, gap, third zero.
        do_reset();
        load(3'b000);
        bit_in(1'b0);
        bit_in(1'b0);
        check("s3_det_two_zeros", int'(det0), 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
            check("s3_det_gap", int'(det0), 0);
        end
        bit_in(1'b0);
        check("s3_det_third_zero", int'(det0), 1);
        check("s3_cnt", int'(cnt0), 1);

        // Saturation on the 2-bit counter, then clear against a same-edge match.
        do_reset();
        load(3'b111);
        for (int i = 0; i < 6; i++) begin
            bit_in(1'b1);
            check($sformatf("s4_cnt_bit%0d", i + 1), int'(cnt2), s4_cnt[i]);
        end
        check("s4_det_sat", int'(det2), 1);
        check("s4_cnt_novl", int'(cnt1), 2);
        step(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1);
        check("s4_clr_det", int'(det2), 1);
        check("s4_clr_cnt", int'(cnt2), 0);

        // Mid-stream load discards the partial match.
        do_reset();
        bit_in(1'b0);
        bit_in(1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 3'b110, 1'b0);
        check("s5_det_on_load", int'(det0), 0);
        bit_in(1'b1);
        check("s5_det_b1", int'(det0), 0);
        bit_in(1'b1);
        check("s5_det_b2", int'(det0), 0);
        bit_in(1'b0);
        check("s5_det_b3", int'(det0), 1);
        check("s5_pat", int'(pat0), 6);

        // Reset mid-operation.
        bit_in(1'b0);
        bit_in(1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        bit_in(1'b1);
        check("s6_det", int'(det0), 0);
        check("s6_pat", int'(pat0), 1);
        check("s6_cnt", int'(cnt0), 0);

        // Pseudo-random stream with gaps, occasional clears and loads, model-checked.
        for (int i = 0; i < 400; i++) begin
            logic [2:0] p;
            p = 3'($urandom_range(0, 7));
            step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 49) == 0), p, 1'($urandom_range(0, 29) == 0));
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_det_prog.md
# seq_det_prog

Programmable serial sequence detector, the parametrised successor of the fixed "001" detector. It samples a 1-bit serial stream qualified by a valid strobe and compares the last N accepted bits against a runtime-loadable pattern. It pulses a registered detect flag on each match and keeps a saturating count of matches. Overlapping versus non-overlapping detection is selected by parameter. It sits on serial front-end/protocol paths wherever framing words or sync marks must be found.

## Interface
- N, default 3: pattern length in bits, N >= 2.
- PATTERN, default 3'b001: N-bit pattern loaded at reset; MSB is the oldest bit, LSB the most recent.
- OVERLAP, default 1: 1 = history is retained after a match (overlapping); 0 = history is discarded after a match.
- CNT_W, default 8: width of the match counter.

Ports:
- clk, input, 1: single clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- inp, input, 1: serial data bit.
- in_valid, input, 1: inp is accepted only at edges where in_valid = 1.
- pat_load, input, 1: load pat_in as the new pattern.
- pat_in, input, N: pattern value to load.
- cnt_clr, input, 1: clear the match counter.
- det, output, 1: registered one-cycle pulse marking a match.
- det_cnt, output, CNT_W: saturating match count.
- pat_cur, output, N: pattern currently in use.

## Operation
- State held by the block:
  - hist[N-1:0]: shift history of accepted bits.
  - fill[clog2(N+1)-1:0]: number of valid bits in hist, 0..N.
  - pat[N-1:0]: active pattern.
- Reset (rst = 1 at an edge): pat <= PATTERN, hist <= 0, fill <= 0, det <= 0, det_cnt <= 0. rst overrides every other input.
- pat_load = 1 at an edge (rst = 0):
  - pat <= pat_in, hist <= 0, fill <= 0, det <= 0.
  - in_valid is ignored on that edge.
  - det_cnt is unchanged.
- Accept (in_valid = 1, pat_load = 0):
  - h' = {hist[N-2:0], inp}; f' = min(fill+1, N).
  - match = (f' == N) && (h' == pat).
- On match:
  - det <= 1.
  - OVERLAP = 1: hist <= h', fill <= N.
  - OVERLAP = 0: hist <= 0, fill <= 0, so the next match needs N fresh bits.
- No match: hist <= h', fill <= f', det <= 0.
- in_valid = 0: hist and fill hold; det <= 0.
- Counter:
  - On match, det_cnt <= det_cnt + 1, saturating at 2^CNT_W - 1 (no wrap).
  - cnt_clr = 1 sets det_cnt <= 0. It has priority over a same-edge match, which still pulses det but is not counted.
  - cnt_clr does not affect hist, fill or pat.
- The fill gate prevents false matches against reset zeros. Example: pattern 000 with only two zeros received since reset gives no det.
- pat_cur = pat.

## Timing
- Latency: det is high for exactly one clock period, starting at the edge that accepted the final pattern bit. There is no combinational path from inp to det.
- det_cnt updates on that same edge.
- Back-to-back detections:
  - OVERLAP = 1: det can be high on consecutive accepted bits (e.g. pattern 111 on a run of ones).
  - OVERLAP = 0: the minimum spacing is N accepted bits.
- in_valid gaps of any length are transparent to matching; det never stays high across a gap cycle.
- A pat_load or rst in the middle of a partial match discards it.
- The new pattern applies to bits accepted from the edge after the load.
- All outputs are 0 (pat_cur = PATTERN) in the first cycle after reset.

## Test plan
- Defaults (N=3, pattern 001, in_valid=1), after rst, inp = 0,0,1,1,0,0,1,1,1,0 -> det high after the 3rd and 7th bits only; det_cnt = 2.
- OVERLAP=1, pat_load 101, inp = 1,0,1,0,1 -> det after the 3rd and 5th bits; det_cnt = 2. With OVERLAP=0, same stimulus -> det after the 3rd bit only; det_cnt = 1.
- Fill gate: pattern 000, after rst inp = 0,0 then in_valid = 0 for 4 cycles, then inp = 0 -> det only after the third accepted 0; det stays low during the gap.
- Saturation and clear, CNT_W=2, OVERLAP=1, pattern 111: six consecutive ones -> det_cnt goes 1,2,3,3 (pulses on bits 3 through 6). Then cnt_clr on the same edge as a match -> det = 1, det_cnt = 0.
- Mid-stream load: default pattern, feed 0,0, then pat_load 110 on the next edge with inp = 1 -> no det and fill = 0. Then inp = 1,1,0 -> det after the 0; pat_cur = 110.
- Reset mid-operation: feed 0,0, assert rst for one edge, then inp = 1 -> no det. pat_cur returns to 001 and det_cnt = 0.
